hazard_sequencer: RTL and testbench

Generates stall and flush controls for the IF/ID pipeline register, the PC register and the ID/EX register of the 5-stage MIPS pipeline. It detects load-use hazards and branch-operand hazards, and sequences multi-cycle mul/div occupancy with an internal busy FSM and counter. StallD drives the IF/ID register EN input (1 = hold). FlushD drives its CLR input.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/md_busy_counter.sv | 70 +++++++
 rtl/hazard_sequencer.sv | 111 +++++++++++
 tb/tb_hazard_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Purpose: shared types and constants for the pipeline hazard sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    // Mul/div occupancy FSM states.
    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Default register-index width (32 architectural registers).
    localparam int REG_W_DEFAULT = 5;

    // Register 0 is hard-wired to zero and never creates a dependency.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/md_busy_counter.sv
// Purpose: mul/div occupancy FSM; counts MD_LAT cycles after each accepted start.
// Latency: busy rises the cycle after start; done pulses on the MD_LAT-th busy cycle.
// Backpressure: start is accepted in IDLE or in the done cycle only; elsewhere it is ignored.
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 6
) (
    input  logic CLK,
    input  logic Reset,
    input  logic start,
    output logic busy,
    output logic done
);

    // MD_LAT must be >= 2 and MD_LAT-1 must fit in CNT_W bits.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // State and remaining-cycle counter, cleared asynchronously by Reset.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: load on start, count down while busy, reload on a start in the done cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt == '0) begin
                    done = 1'b1;
                    if (start) begin
                        cnt_nxt = CNT_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Busy is a direct decode of the state flop, so it is glitch-free.
    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_sequencer.sv
// Purpose: stall/flush control for PC, IF/ID and ID/EX (load-use, branch-operand, mul/div hazards).
// Latency: stall/flush outputs are combinational (same cycle); MdBusy registered.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; a redirect under stall waits for release.
// Build option: define HAZ_PERF_CNT_EN to enable the saturating StallCnt/FlushCnt counters.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int REG_W  = REG_W_DEFAULT,
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 6
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic             BranchD,
    input  logic             RedirectD,
    input  logic             MdStartD,
    input  logic             MdUseD,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic             MemtoRegM,
    input  logic [REG_W-1:0] WriteRegM,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MdBusy,
    output logic             MdDone,
    output logic [31:0]      StallCnt,
    output logic [31:0]      FlushCnt
);

    localparam logic [REG_W-1:0] ZERO_R = REG_W'(ZERO_REG);

    logic match_e_rs;
    logic match_e_rt;
    logic match_m_rs;
    logic match_m_rt;
    logic lwstall;
    logic brstall;
    logic mdstall;
    logic stall;
    logic md_start;
    logic md_busy;
    logic md_done;

    // A producer only matters if it writes a real (non-zero) register.
    assign match_e_rs = RegWriteE && (WriteRegE != ZERO_R) && (WriteRegE == RsD);
    assign match_e_rt = RegWriteE && (WriteRegE != ZERO_R) && (WriteRegE == RtD);
    assign match_m_rs = MemtoRegM && (WriteRegM != ZERO_R) && (WriteRegM == RsD);
    assign match_m_rt = MemtoRegM && (WriteRegM != ZERO_R) && (WriteRegM == RtD);

    // Load in EX feeding ID: data not available until after MEM.
    assign lwstall = MemtoRegE && (match_e_rs || match_e_rt);
    // Branch compares in ID, so any EX result or MEM load it reads is too late.
    assign brstall = BranchD && (match_e_rs || match_e_rt || match_m_rs || match_m_rt);
    // HI/LO consumers wait until the final busy cycle.
    assign mdstall = MdUseD && md_busy && !md_done;

    assign stall  = lwstall || brstall || mdstall;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    assign FlushD = RedirectD && !stall;

    // A stalled start is not issued; it is presented again next cycle.
    assign md_start = MdStartD && !stall;

    md_busy_counter #(
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) u_md_busy_counter (
        .CLK   (CLK),
        .Reset (Reset),
        .start (md_start),
        .busy  (md_busy),
        .done  (md_done)
    );

    assign MdBusy = md_busy;
    assign MdDone = md_done;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (FlushD && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign StallCnt = stall_cnt;
    assign FlushCnt = flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Purpose: self-checking bench for hazard_sequencer with a cycle-interval reference model.
// Latency: expected outputs are compared in the same cycle the inputs are applied.
// Backpressure: n/a (bench drives every cycle; scoreboard drains each cycle).
module tb_hazard_sequencer;

    localparam int REG_W  = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 6;

    logic             CLK = 1'b0;
    logic             Reset;
    logic [REG_W-1:0] RsD;
    logic [REG_W-1:0] RtD;
    logic             BranchD;
    logic             RedirectD;
    logic             MdStartD;
    logic             MdUseD;
    logic             RegWriteE;
    logic             MemtoRegE;
    logic [REG_W-1:0] WriteRegE;
    logic             MemtoRegM;
    logic [REG_W-1:0] WriteRegM;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             MdBusy;
    logic             MdDone;
    logic [31:0]      StallCnt;
    logic [31:0]      FlushCnt;

    hazard_sequencer #(
        .REG_W  (REG_W),
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .RsD       (RsD),
        .RtD       (RtD),
        .BranchD   (BranchD),
        .RedirectD (RedirectD),
        .MdStartD  (MdStartD),
        .MdUseD    (MdUseD),
        .RegWriteE (RegWriteE),
        .MemtoRegE (MemtoRegE),
        .WriteRegE (WriteRegE),
        .MemtoRegM (MemtoRegM),
        .WriteRegM (WriteRegM),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .MdBusy    (MdBusy),
        .MdDone    (MdDone),
        .StallCnt  (StallCnt),
        .FlushCnt  (FlushCnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        stall;
        logic        flushd;
        logic        busy;
        logic        done;
        logic [31:0] scnt;
        logic [31:0] fcnt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mul/div occupancy is the cycle interval (last_issue, last_issue+MD_LAT].
    int          cyc        = 0;
    int          last_issue = -1000;
    logic [31:0] m_scnt     = '0;
    logic [31:0] m_fcnt     = '0;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic set_idle();
        RsD = '0; RtD = '0; BranchD = 0; RedirectD = 0; MdStartD = 0; MdUseD = 0;
        RegWriteE = 0; MemtoRegE = 0; WriteRegE = '0; MemtoRegM = 0; WriteRegM = '0;
    endtask

    // Apply current inputs for one cycle: predict outputs, queue them, advance the model.
    task automatic step(input logic rst);
        logic me_rs, me_rt, mm_rs, mm_rt, busy, done, lw, br, md, stall, fd;
        exp_t e;
        Reset = rst;
        me_rs = RegWriteE && WriteRegE != 0 && WriteRegE == RsD;
        me_rt = RegWriteE && WriteRegE != 0 && WriteRegE == RtD;
        mm_rs = MemtoRegM && WriteRegM != 0 && WriteRegM == RsD;
        mm_rt = MemtoRegM && WriteRegM != 0 && WriteRegM == RtD;
        busy  = rst && (cyc > last_issue) && (cyc <= last_issue + MD_LAT);
        done  = busy && (cyc == last_issue + MD_LAT);
        lw    = MemtoRegE && (me_rs || me_rt);
        br    = BranchD && (me_rs || me_rt || mm_rs || mm_rt);
        md    = MdUseD && busy && !done;
        stall = lw || br || md;
        fd    = RedirectD && !stall;
        e.stall  = stall;
        e.flushd = fd;
        e.busy   = busy;
        e.done   = done;
        e.cyc    = cyc;
`ifdef HAZ_PERF_CNT_EN
        e.scnt = rst ? m_scnt : 32'd0;
        e.fcnt = rst ? m_fcnt : 32'd0;
`else
        e.scnt = 32'd0;
        e.fcnt = 32'd0;
`endif
        sb.push_back(e);
        if (!rst) begin
            last_issue = -1000;
            m_scnt     = '0;
            m_fcnt     = '0;
        end else begin
            if (MdStartD && !stall && (!busy || done)) last_issue = cyc;
            if (stall && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            if (fd && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
        end
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every cycle the DUT presents its outputs; compare against the queued prediction.
    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("StallF",   mon_e.cyc, 32'(StallF),  32'(mon_e.stall));
            chk("StallD",   mon_e.cyc, 32'(StallD),  32'(mon_e.stall));
            chk("FlushE",   mon_e.cyc, 32'(FlushE),  32'(mon_e.stall));
            chk("FlushD",   mon_e.cyc, 32'(FlushD),  32'(mon_e.flushd));
            chk("MdBusy",   mon_e.cyc, 32'(MdBusy),  32'(mon_e.busy));
            chk("MdDone",   mon_e.cyc, 32'(MdDone),  32'(mon_e.done));
            chk("StallCnt", mon_e.cyc, StallCnt,     mon_e.scnt);
            chk("FlushCnt", mon_e.cyc, FlushCnt,     mon_e.fcnt);
        end
    end

    initial begin
        set_idle();
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        // Reset held: everything zero.
        step(0);
        step(0);
        step(1);

        // Load-use on Rs, with a redirect that must be suppressed.
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5'd8; RsD = 5'd8; RedirectD = 1;
        step(1);
        set_idle(); step(1);

        // Register 0 never stalls.
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5'd0; RsD = 5'd0;
        step(1);
        set_idle(); step(1);

        // Branch operand produced by a load in MEM, then no load, then redirect.
        BranchD = 1; MemtoRegM = 1; WriteRegM = 5'd5; RtD = 5'd5;
        step(1);
        MemtoRegM = 0;
        step(1);
        set_idle(); RedirectD = 1;
        step(1);
        set_idle(); step(1);

        // Mul/div, consumer held, back-to-back start in the done cycle.
        MdStartD = 1; MdUseD = 1; step(1);
        MdStartD = 0; step(1); step(1); step(1);
        MdStartD = 1; step(1);
        MdStartD = 0; step(1); step(1); step(1); step(1);
        set_idle(); step(1); step(1);

        // Three load-use stalls, then reset in the middle of a busy period.
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5'd3; RtD = 5'd3;
        step(1); step(1); step(1);
        set_idle(); step(1);
        MdStartD = 1; MdUseD = 1; step(1);
        set_idle(); step(1);
        step(0);
        step(0);
        step(1);
        step(1);

        // Randomized traffic with small register space to provoke matches.
        for (int i = 0; i < 600; i++) begin
            RsD       = REG_W'($urandom_range(0, 3));
            RtD       = REG_W'($urandom_range(0, 3));
            WriteRegE = REG_W'($urandom_range(0, 3));
            WriteRegM = REG_W'($urandom_range(0, 3));
            RegWriteE = ($urandom_range(0, 1) == 1);
            MemtoRegE = ($urandom_range(0, 2) == 0);
            MemtoRegM = ($urandom_range(0, 2) == 0);
            BranchD   = ($urandom_range(0, 3) == 0);
            RedirectD = ($urandom_range(0, 3) == 0);
            MdStartD  = ($urandom_range(0, 7) == 0);
            MdUseD    = MdStartD || ($urandom_range(0, 1) == 1);
            step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0);
        end
        set_idle();
        step(1);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge CLK);
        @(negedge CLK);
        chk("sb_drain", cyc, 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
